cordic_iter_ctrl: RTL
=====================

// Module: cordic_iter_ctrl
// PURPOSE
//  Iterative sequencer that drives the single combinational cordic stage: latches an
//  (x,y,z,mode) job, presents it to the stage, registers the stage outputs back each cycle,
//  and supplies the per-iteration shift amount, LUT angle and direction bit.
//  Returns the final (x,y,z) through a valid/ready output handshake. Rotation mode only.
// PARAMETERS
//  p_WIDTH   32  datapath width; fixed at 32 because the stage derives d from bit 31
//  p_ITER    24  total stage evaluations per job, including hyperbolic repeats; 1..p_WIDTH-4
// PORTS
//  i_clk        in   1        clock; all state changes on the rising edge
//  i_rst_n      in   1        asynchronous, active-low reset
//  i_valid      in   1        input job valid
//  o_ready      out  1        block can accept a job (high only in IDLE)
//  i_x,i_y,i_z  in   p_WIDTH  signed job operands; z is an angle in Q3.29
//  i_mode       in   1        0 = hyperbolic, 1 = circular (stage encoding)
//  o_valid      out  1        result valid
//  i_ready      in   1        downstream accepts the result
//  o_x,o_y,o_z  out  p_WIDTH  signed results; held stable while o_valid && !i_ready
//  o_xprev,o_yprev,o_zprev  out  p_WIDTH  to stage: current iteration registers
//  o_dprev      out  1        to stage: direction (1 means d=+1)
//  o_mode       out  1        to stage: latched mode
//  o_lut        out  p_WIDTH  to stage: angle for the current shift
//  o_shift_amnt out  5        to stage: current shift ($clog2(p_WIDTH) bits)
//  i_xnext,i_ynext,i_znext  in  p_WIDTH  from stage
//  i_dnext      in   1        from stage: direction for the next iteration
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; o_valid=0; o_ready=1; o_x/o_y/o_z, working regs,
//   iter count, shift and o_dprev = 0; o_mode=1. Any in-flight job is discarded without output.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: o_ready=1. On i_valid: latch x,y,z,mode into the working regs; o_dprev=~i_z[31];
//   shift = mode ? 0 : 1; iter=0; clear the hyperbolic repeat flags; go to RUN.
//  RUN (o_ready=0, o_valid=0), each cycle:
//   - working regs <= i_xnext/i_ynext/i_znext; o_dprev <= i_dnext; iter <= iter+1.
//   - Shift advance: +1 per iteration, except in hyperbolic mode, where shifts 4 and 13 are
//     each issued twice (first issue sets a repeat flag; the second issue advances).
//     Sequence: 1,2,3,4,4,5..13,13,14..
//   - When iter==p_ITER-1 on this edge: go to DONE; o_x/o_y/o_z <= i_*next.
//  DONE: o_valid=1. Transfer on o_valid && i_ready, then go to IDLE.
//   o_ready stays 0 in DONE, so a new job is never accepted in the same cycle as a result
//   transfer.
//  Latency: accepted job -> o_valid asserted exactly p_ITER+1 clocks later (result registered).
//   Throughput: one job per p_ITER+2 clocks when i_ready is held high.
//  i_valid outside IDLE is ignored; the input job is not consumed.
//  Mode and operands are frozen for the whole job; changing i_mode in RUN has no effect.
//  LUT: o_lut = round(atan(2^-s)*2^29) when circular, round(atanh(2^-s)*2^29) when hyperbolic.
//   Hyperbolic s=0 is unreachable and returns 0.
//  Arithmetic is owned by the stage; this block never widens, saturates or rescales data.
//  No gain compensation: the caller pre-scales x (circular K=0.60725; hyperbolic 1/Kh=1.20750).
// STRUCTURE
//  cordic_pkg: state enum {IDLE,RUN,DONE}; MODE_HYP=0 and MODE_CIRC=1; Q3.29 scale constant;
//   hyperbolic repeat shifts (4, 13).
//  Sub-module cordic_angle_lut: combinational ROM; (mode, shift) -> angle.
//   Tables are generated as constants in cordic_pkg.
//  The bench instantiates the cordic stage and wires o_*prev/i_*next between the two blocks.
// TESTING
//  1 Circular: x=0.60725*2^29, y=0, z=pi/4*2^29 -> o_x = o_y = 0.70711*2^29 +/-256 LSB;
//    o_z ~0 within +/-256 LSB.
//  2 Hyperbolic: x=1.20750*2^29, y=0, z=0.5*2^29 -> o_x=cosh(0.5)=1.12763*2^29 and
//    o_y=sinh(0.5)=0.52110*2^29, both +/-512 LSB. Check o_shift_amnt trace 1,2,3,4,4,5..
//  3 Timing: i_valid held high with i_ready=1 -> accepts spaced exactly p_ITER+2 clocks;
//    o_valid exactly p_ITER+1 clocks after each accept; o_ready=0 throughout RUN/DONE.
//  4 Backpressure: i_ready=0 for 10 cycles in DONE -> o_valid stays 1; o_x/o_y/o_z stable;
//    no new job is accepted despite i_valid=1.
//  5 Reset mid-RUN: assert i_rst_n=0 at iteration 7 -> outputs take reset values immediately
//    (asynchronously); no o_valid pulse; a fresh job afterwards completes correctly.
//  6 Negative angle: circular with z=-pi/4*2^29 -> o_dprev=0 on the first iteration;
//    o_y = -0.70711*2^29 +/-256 LSB.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC sequencer.
// Angles are Q3.29 signed fixed point: 1.0 rad == 2^29 LSB.
package cordic_pkg;

    // Datapath and shift-amount widths. The stage takes the direction
    // from bit 31, so the datapath is fixed at 32 bits.
    localparam int DATA_W  = 32;
    localparam int SHIFT_W = 5;

    // Q3.29 scale: number of fractional bits and the value of 1.0.
    localparam int          Q_FRAC = 29;
    localparam logic [31:0] Q_ONE  = 32'h2000_0000;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Mode encoding as seen by the stage.
    localparam logic MODE_HYP  = 1'b0;
    localparam logic MODE_CIRC = 1'b1;

    // Hyperbolic shifts that must be issued twice for convergence.
    localparam logic [SHIFT_W-1:0] HYP_REPEAT_A = 5'd4;
    localparam logic [SHIFT_W-1:0] HYP_REPEAT_B = 5'd13;

    // round(atan(2^-s) * 2^29), s = 0..31.
    localparam logic [31:0] ATAN_TABLE [0:31] = '{
        32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579,
        32'd33510843,  32'd16771758,  32'd8387925,   32'd4194219,
        32'd2097141,   32'd1048575,   32'd524288,    32'd262144,
        32'd131072,    32'd65536,     32'd32768,     32'd16384,
        32'd8192,      32'd4096,      32'd2048,      32'd1024,
        32'd512,       32'd256,       32'd128,       32'd64,
        32'd32,        32'd16,        32'd8,         32'd4,
        32'd2,         32'd1,         32'd0,         32'd0
    };

    // round(atanh(2^-s) * 2^29), s = 0..31. s = 0 is unreachable (atanh(1)
    // is infinite) and holds 0.
    localparam logic [31:0] ATANH_TABLE [0:31] = '{
        32'd0,         32'd294906491, 32'd137123709, 32'd67461703,
        32'd33598225,  32'd16782681,  32'd8389291,   32'd4194389,
        32'd2097163,   32'd1048577,   32'd524288,    32'd262144,
        32'd131072,    32'd65536,     32'd32768,     32'd16384,
        32'd8192,      32'd4096,      32'd2048,      32'd1024,
        32'd512,       32'd256,       32'd128,       32'd64,
        32'd32,        32'd16,        32'd8,         32'd4,
        32'd2,         32'd1,         32'd1,         32'd0
    };

    // First shift of a job: circular starts at 2^0, hyperbolic at 2^-1.
    function automatic logic [SHIFT_W-1:0] first_shift(input logic mode);
        return (mode == MODE_CIRC) ? 5'd0 : 5'd1;
    endfunction

endpackage

// File: rtl/cordic_angle_lut.sv
// Combinational angle ROM: (mode, shift) -> elementary rotation angle in Q3.29.
module cordic_angle_lut
    import cordic_pkg::*;
(
    input  logic               i_mode,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [DATA_W-1:0]  o_angle
);

    // Select the circular or hyperbolic table entry for the current shift.
    always_comb begin
        o_angle = '0;
        if (i_mode == MODE_CIRC) begin
            o_angle = ATAN_TABLE[i_shift];
        end else begin
            o_angle = ATANH_TABLE[i_shift];
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer (rotation mode). Owns the working registers
// around a single external combinational stage, steps the shift amount
// (with hyperbolic repeats at 4 and 13) and returns the final vector.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Input side: o_ready is high only in IDLE; i_valid elsewhere is ignored and
// the offered job stays un-consumed. Output side: o_valid is high only in
// DONE and o_x/o_y/o_z hold until i_ready; o_ready stays low in DONE so an
// accept never coincides with a result transfer.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int p_WIDTH = DATA_W,
    parameter int p_ITER  = 24
)
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    // job input
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [p_WIDTH-1:0] i_x,
    input  logic [p_WIDTH-1:0] i_y,
    input  logic [p_WIDTH-1:0] i_z,
    input  logic               i_mode,
    // result output
    output logic               o_valid,
    input  logic               i_ready,
    output logic [p_WIDTH-1:0] o_x,
    output logic [p_WIDTH-1:0] o_y,
    output logic [p_WIDTH-1:0] o_z,
    // to stage
    output logic [p_WIDTH-1:0] o_xprev,
    output logic [p_WIDTH-1:0] o_yprev,
    output logic [p_WIDTH-1:0] o_zprev,
    output logic               o_dprev,
    output logic               o_mode,
    output logic [p_WIDTH-1:0] o_lut,
    output logic [SHIFT_W-1:0] o_shift_amnt,
    // from stage
    input  logic [p_WIDTH-1:0] i_xnext,
    input  logic [p_WIDTH-1:0] i_ynext,
    input  logic [p_WIDTH-1:0] i_znext,
    input  logic               i_dnext,
    // observability
    output logic [1:0]         o_dbg_state
);

    localparam logic [SHIFT_W-1:0] LP_LAST = SHIFT_W'(p_ITER - 1);
    localparam logic [SHIFT_W-1:0] LP_ONE  = SHIFT_W'(1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_load;
    logic                 w_step;
    logic                 w_last;

    logic [p_WIDTH-1:0]   r_x;
    logic [p_WIDTH-1:0]   r_y;
    logic [p_WIDTH-1:0]   r_z;
    logic                 r_dprev;
    logic                 r_mode;
    logic [SHIFT_W-1:0]   r_shift;
    logic [SHIFT_W-1:0]   r_iter;
    logic                 r_rep_a;
    logic                 r_rep_b;
    logic [p_WIDTH-1:0]   r_out_x;
    logic [p_WIDTH-1:0]   r_out_y;
    logic [p_WIDTH-1:0]   r_out_z;

    logic [SHIFT_W-1:0]   w_shift_next;
    logic                 w_rep_a_next;
    logic                 w_rep_b_next;
    logic [DATA_W-1:0]    w_angle;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_load       = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_iter == LP_LAST) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Shift advance: +1 per iteration; hyperbolic 4 and 13 are issued twice,
    // the first issue only arming the repeat flag.
    always_comb begin
        w_shift_next = r_shift + LP_ONE;
        w_rep_a_next = r_rep_a;
        w_rep_b_next = r_rep_b;
        if (r_mode == MODE_HYP) begin
            if ((r_shift == HYP_REPEAT_A) && !r_rep_a) begin
                w_shift_next = r_shift;
                w_rep_a_next = 1'b1;
            end else if ((r_shift == HYP_REPEAT_B) && !r_rep_b) begin
                w_shift_next = r_shift;
                w_rep_b_next = 1'b1;
            end
        end
    end

    // Working registers: load the job in IDLE, capture the stage each RUN cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_dprev <= 1'b0;
            r_mode  <= MODE_CIRC;
            r_shift <= '0;
            r_iter  <= '0;
            r_rep_a <= 1'b0;
            r_rep_b <= 1'b0;
        end else if (w_load) begin
            r_x     <= i_x;
            r_y     <= i_y;
            r_z     <= i_z;
            r_dprev <= ~i_z[p_WIDTH-1];
            r_mode  <= i_mode;
            r_shift <= first_shift(i_mode);
            r_iter  <= '0;
            r_rep_a <= 1'b0;
            r_rep_b <= 1'b0;
        end else if (w_step) begin
            r_x     <= i_xnext;
            r_y     <= i_ynext;
            r_z     <= i_znext;
            r_dprev <= i_dnext;
            r_shift <= w_shift_next;
            r_iter  <= r_iter + LP_ONE;
            r_rep_a <= w_rep_a_next;
            r_rep_b <= w_rep_b_next;
        end
    end

    // Result registers: captured from the stage on the final iteration and
    // held until the next job finishes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_x <= '0;
            r_out_y <= '0;
            r_out_z <= '0;
        end else if (w_last) begin
            r_out_x <= i_xnext;
            r_out_y <= i_ynext;
            r_out_z <= i_znext;
        end
    end

    cordic_angle_lut u_lut (
        .i_mode  (r_mode),
        .i_shift (r_shift),
        .o_angle (w_angle)
    );

    assign o_x          = r_out_x;
    assign o_y          = r_out_y;
    assign o_z          = r_out_z;
    assign o_xprev      = r_x;
    assign o_yprev      = r_y;
    assign o_zprev      = r_z;
    assign o_dprev      = r_dprev;
    assign o_mode       = r_mode;
    assign o_lut        = w_angle;
    assign o_shift_amnt = r_shift;
    assign o_dbg_state  = r_state;

endmodule
